// File: rtl/dyn_link_coding_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dyn_link_coding_pkg
// Description : Shared definitions for the dynamic_node link coding blocks.
//               Holds the coder mode encodings, the default width of the
//               inversion statistics counter and a helper that sizes a
//               popcount result for a given bus width.
// Revision    : 1.0 - initial release
// ============================================================================
package dyn_link_coding_pkg;

    // Coder operating modes
    localparam int MODE_ENCODE = 0;
    localparam int MODE_DECODE = 1;

    // Default width of the saturating inversion counter
    localparam int DEFAULT_CNT_W = 16;

    // Number of bits needed to hold a count of 0..width set bits
    function automatic int popcount_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage : dyn_link_coding_pkg
`default_nettype wire

// File: rtl/link_popcount.sv
`default_nettype none
// ============================================================================
// Module      : link_popcount
// Description : Combinational population count built as a balanced binary
//               adder tree. The input is padded with zeros up to the next
//               power of two so every tree level is uniform.
// Ports       : data  [WIDTH-1:0]                    word to count
//               count [popcount_width(WIDTH)-1:0]    number of set bits
// Revision    : 1.0 - initial release
// ============================================================================
module link_popcount
    import dyn_link_coding_pkg::*;
#(
    parameter int WIDTH = 64
) (
    input  logic [WIDTH-1:0]                 data,
    output logic [popcount_width(WIDTH)-1:0] count
);

    localparam int c_cw     = popcount_width(WIDTH);
    localparam int c_levels = $clog2(WIDTH);
    localparam int c_leaves = 1 << c_levels;

    // Heap-ordered tree: node n sums nodes 2n and 2n+1, leaves sit at
    // indices c_leaves..2*c_leaves-1, the root is node 1. Every node uses
    // the full result width; no partial sum can exceed WIDTH.
    logic [c_cw-1:0] w_node [1:2*c_leaves-1];

    generate
        for (genvar k = 0; k < c_leaves; k++) begin : g_leaf
            if (k < WIDTH) begin : g_bit
                assign w_node[c_leaves+k] = {{(c_cw-1){1'b0}}, data[k]};
            end else begin : g_pad
                assign w_node[c_leaves+k] = '0;
            end
        end

        for (genvar n = 1; n < c_leaves; n++) begin : g_sum
            assign w_node[n] = w_node[2*n] + w_node[2*n+1];
        end
    endgenerate

    assign count = w_node[1];

endmodule : link_popcount
`default_nettype wire

// File: rtl/bus_invert_link_coder.sv
`default_nettype none
// ============================================================================
// Module      : bus_invert_link_coder
// Description : Registered, valid/ready flow-controlled bus-invert coder for
//               dynamic_node link wires.
//               MODE=0 (encode): a flit is inverted only when that lowers the
//               number of wire transitions against the word last driven; the
//               choice is reported on out_inv.
//               MODE=1 (decode): the original flit is restored from the link
//               data and its invert flag.
//               Single output register stage, 1-cycle latency, full
//               throughput while out_rdy is high.
// Ports       : clk, reset         clock, synchronous active-high reset
//               in_data/in_inv     incoming flit and link invert flag
//                                  (in_inv used in decode mode only)
//               in_val/in_rdy      input handshake
//               out_data/out_inv   registered coded/restored flit and flag
//               out_val/out_rdy    output handshake
//               inv_count          saturating count of inverted flits
// Revision    : 1.0 - initial release
// ============================================================================
module bus_invert_link_coder
    import dyn_link_coding_pkg::*;
#(
    parameter int WIDTH  = 64,
    parameter int MODE   = MODE_ENCODE,
    parameter int THRESH = WIDTH / 2,
    parameter int CNT_W  = DEFAULT_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_inv,
    input  logic             in_val,
    output logic             in_rdy,
    output logic [WIDTH-1:0] out_data,
    output logic             out_inv,
    output logic             out_val,
    input  logic             out_rdy,
    output logic [CNT_W-1:0] inv_count
);

    logic [WIDTH-1:0] r_out_data;
    logic             r_out_inv;
    logic             r_out_val;
    logic [CNT_W-1:0] r_inv_count;

    logic             w_accept;
    logic             w_inv;
    logic [WIDTH-1:0] w_coded;

    // The output register can take a new flit when it is empty or is being
    // drained on this same edge.
    assign in_rdy   = ~r_out_val | out_rdy;
    assign w_accept = in_val & in_rdy;

    generate
        if (MODE == MODE_ENCODE) begin : g_encode
            localparam int c_cw = popcount_width(WIDTH);
            // A threshold at or above WIDTH can never be exceeded, so clamp
            // it to WIDTH to keep it representable in the distance width.
            localparam logic [c_cw-1:0] c_thresh =
                (THRESH >= WIDTH) ? c_cw'(WIDTH) : c_cw'(THRESH);

            logic [WIDTH-1:0] r_prev_wire;
            logic [WIDTH-1:0] w_diff;
            logic [c_cw-1:0]  w_dist;
            logic             w_unused_inv;

            // The link flag is only meaningful to a decoder.
            assign w_unused_inv = in_inv;

            assign w_diff = in_data ^ r_prev_wire;

            link_popcount #(
                .WIDTH (WIDTH)
            ) u_popcount (
                .data  (w_diff),
                .count (w_dist)
            );

            // A tie (distance == threshold) is sent as-is.
            assign w_inv   = (w_dist > c_thresh);
            assign w_coded = w_inv ? ~in_data : in_data;

            // Last value placed on the wire; only moves on an accepted flit,
            // so a drained or stalled output keeps the reference stable.
            always_ff @(posedge clk) begin
                if (reset) begin
                    r_prev_wire <= '0;
                end else if (w_accept) begin
                    r_prev_wire <= w_coded;
                end
            end
        end else begin : g_decode
            assign w_inv   = in_inv;
            assign w_coded = in_data ^ {WIDTH{in_inv}};
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            r_out_data  <= '0;
            r_out_inv   <= 1'b0;
            r_out_val   <= 1'b0;
            r_inv_count <= '0;
        end else begin
            if (w_accept) begin
                r_out_data <= w_coded;
                r_out_inv  <= w_inv;
                r_out_val  <= 1'b1;
            end else if (out_rdy) begin
                // Drained with nothing new: data and flag stay on the wire.
                r_out_val  <= 1'b0;
            end

            if (w_accept && w_inv && (r_inv_count != {CNT_W{1'b1}})) begin
                r_inv_count <= r_inv_count + CNT_W'(1);
            end
        end
    end

    assign out_data  = r_out_data;
    assign out_inv   = r_out_inv;
    assign out_val   = r_out_val;
    assign inv_count = r_inv_count;

endmodule : bus_invert_link_coder
`default_nettype wire
